// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external combinational ALU between two requesters.
// Requests are arbitrated round-robin. The winner's opcode and operands are
// registered onto the ALU inputs for one EXEC cycle. The ALU result is then
// captured and returned on a single response channel tagged with the requester id.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/op/a/b        requester N operation (N = 0, 1)
//   reqN_ready               combinational accept for requester N
//   rsp_valid/id/data/err    registered response channel, held until rsp_ready
//   rsp_ready                consumer accepts the response
//   alu_op_o/alu_a_o/alu_b_o registered drive to the external ALU
//   alu_res_i                result from the external ALU
module alu_share_ctrl #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned OP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [OP_WIDTH-1:0] req0_op,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [OP_WIDTH-1:0] req1_op,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  output logic                req1_ready,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [WIDTH:0]      rsp_data,
  output logic                rsp_err,
  input  logic                rsp_ready,
  output logic [OP_WIDTH-1:0] alu_op_o,
  output logic [WIDTH-1:0]    alu_a_o,
  output logic [WIDTH-1:0]    alu_b_o,
  input  logic [WIDTH:0]      alu_res_i
);

  localparam logic [OP_WIDTH-1:0] OP_FIRST_LEGAL = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_LAST_LEGAL  = OP_WIDTH'(5);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;          // 1: port 1 wins a tie
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [WIDTH:0]        rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0]      alu_a_q, alu_a_d;
  logic [WIDTH-1:0]      alu_b_q, alu_b_d;

  logic                  grant0_c, grant1_c;
  logic [OP_WIDTH-1:0]   sel_op_c;

  // Round-robin grant; the pointer only matters when both ports are valid.
  always_comb begin
    grant1_c   = req1_valid && (!req0_valid || ptr_q);
    grant0_c   = req0_valid && !grant1_c;
    req0_ready = (state_q == IDLE) && grant0_c;
    req1_ready = (state_q == IDLE) && grant1_c;
    sel_op_c   = grant1_c ? req1_op : req0_op;
  end

  // Next-state and datapath loads.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;

    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          alu_op_d  = sel_op_c;
          alu_a_d   = grant1_c ? req1_a : req0_a;
          alu_b_d   = grant1_c ? req1_b : req0_b;
          rsp_id_d  = grant1_c;
          rsp_err_d = (sel_op_c < OP_FIRST_LEGAL) || (sel_op_c > OP_LAST_LEGAL);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // ALU is combinational: its result is valid by the end of EXEC.
        rsp_data_d  = alu_res_i;
        rsp_valid_d = 1'b1;
        alu_op_d    = '0;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ~rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_op_o  = alu_op_q;
  assign alu_a_o   = alu_a_q;
  assign alu_b_o   = alu_b_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl. It models the external ALU and runs directed
// scenarios and then random traffic. The expected responses are kept in a
// scoreboard queue, and a separate monitor checks them.
module tb_alu_share_ctrl;

  localparam int unsigned WIDTH    = 7;
  localparam int unsigned OP_WIDTH = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                req0_valid, req1_valid;
  logic [OP_WIDTH-1:0] req0_op, req1_op;
  logic [WIDTH-1:0]    req0_a, req0_b, req1_a, req1_b;
  logic                req0_ready, req1_ready;
  logic                rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [WIDTH:0]      rsp_data;
  logic [OP_WIDTH-1:0] alu_op_o;
  logic [WIDTH-1:0]    alu_a_o, alu_b_o;
  logic [WIDTH:0]      alu_res_i;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_res_i(alu_res_i)
  );

  // Reference ALU: 1 add, 2 sub, 3 and, 4 or, 5 xor, anything else yields 0.
  function automatic logic [WIDTH:0] alu_ref(input logic [OP_WIDTH-1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] xa, xb;
    xa = {1'b0, a};
    xb = {1'b0, b};
    case (op)
      3'd1:    return xa + xb;
      3'd2:    return xa - xb;
      3'd3:    return xa & xb;
      3'd4:    return xa | xb;
      3'd5:    return xa ^ xb;
      default: return '0;
    endcase
  endfunction

  always_comb alu_res_i = alu_ref(alu_op_o, alu_a_o, alu_b_o);

  typedef struct {
    logic           id;
    logic [WIDTH:0] data;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Staged stimulus, applied at each falling edge.
  logic                s_rst, s_v0, s_v1, s_rdy, s_keep;
  logic [OP_WIDTH-1:0] s_op0, s_op1;
  logic [WIDTH-1:0]    s_a0, s_b0, s_a1, s_b1;

  // Transaction-level model: one op in flight, response visible two cycles after accept.
  logic                m_busy, m_ptr, m_id, after_rst;
  int                  cyc, t_xfer;
  logic [OP_WIDTH-1:0] m_op;
  logic [WIDTH-1:0]    m_a, m_b;

  task automatic cycle();
    logic g0, g1, exp_rv, exp_exec;
    exp_t e;
    @(negedge clk);
    rst        = s_rst;
    req0_valid = s_v0; req0_op = s_op0; req0_a = s_a0; req0_b = s_b0;
    req1_valid = s_v1; req1_op = s_op1; req1_a = s_a1; req1_b = s_b1;
    rsp_ready  = s_rdy;
    #1;
    cyc++;
    if (rst) begin
      m_busy    = 1'b0;
      m_ptr     = 1'b0;
      after_rst = 1'b1;
      sb_q.delete();
      return;
    end
    if (after_rst) begin
      check("rst_rsp_id",   32'(rsp_id),   32'(0));
      check("rst_rsp_data", 32'(rsp_data), 32'(0));
      check("rst_rsp_err",  32'(rsp_err),  32'(0));
      check("rst_alu_a",    32'(alu_a_o),  32'(0));
      check("rst_alu_b",    32'(alu_b_o),  32'(0));
      after_rst = 1'b0;
    end
    exp_rv   = m_busy && (cyc >= t_xfer + 2);
    exp_exec = m_busy && (cyc == t_xfer + 1);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("alu_op_o",  32'(alu_op_o),  exp_exec ? 32'(m_op) : 32'(0));
    if (exp_exec) begin
      check("alu_a_o", 32'(alu_a_o), 32'(m_a));
      check("alu_b_o", 32'(alu_b_o), 32'(m_b));
    end
    g0 = 1'b0;
    g1 = 1'b0;
    if (!m_busy) begin
      if (s_v0 && s_v1) begin
        g1 = m_ptr;
        g0 = !m_ptr;
      end else begin
        g0 = s_v0;
        g1 = s_v1;
      end
    end
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    check("one_ready",  32'(req0_ready & req1_ready), 32'(0));
    if (exp_rv && s_rdy) begin
      m_busy = 1'b0;
      m_ptr  = !m_id;
    end
    if (g0 || g1) begin
      m_id   = g1;
      m_op   = g1 ? s_op1 : s_op0;
      m_a    = g1 ? s_a1 : s_a0;
      m_b    = g1 ? s_b1 : s_b0;
      e.id   = g1;
      e.data = alu_ref(m_op, m_a, m_b);
      e.err  = (m_op < 3'd1) || (m_op > 3'd5);
      sb_q.push_back(e);
      m_busy = 1'b1;
      t_xfer = cyc;
      if (!s_keep) begin
        if (g0) s_v0 = 1'b0;
        if (g1) s_v1 = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: every presented response must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'(0));
        end else begin
          check("rsp_id",   32'(rsp_id),   32'(sb_q[0].id));
          check("rsp_data", 32'(rsp_data), 32'(sb_q[0].data));
          check("rsp_err",  32'(rsp_err),  32'(sb_q[0].err));
          if (rsp_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    s_rst = 1'b1; s_v0 = 1'b0; s_v1 = 1'b0; s_rdy = 1'b1; s_keep = 1'b0;
    s_op0 = '0; s_a0 = '0; s_b0 = '0; s_op1 = '0; s_a1 = '0; s_b1 = '0;
    m_busy = 1'b0; m_ptr = 1'b0; m_id = 1'b0; after_rst = 1'b0;
    m_op = '0; m_a = '0; m_b = '0;
    cyc = 0; t_xfer = -10;
    run(2);
    s_rst = 1'b0;

    // Single add on port 0.
    s_v0 = 1'b1; s_op0 = 3'd1; s_a0 = 7'd5; s_b0 = 7'd3;
    run(5);

    // Subtract wrap and add carry on port 1.
    s_v1 = 1'b1; s_op1 = 3'd2; s_a1 = 7'd3; s_b1 = 7'd5;
    run(4);
    s_v1 = 1'b1; s_op1 = 3'd1; s_a1 = 7'd127; s_b1 = 7'd1;
    run(4);

    // Continuous contention from reset.
    s_rst = 1'b1; run(1); s_rst = 1'b0;
    s_keep = 1'b1;
    s_v0 = 1'b1; s_op0 = 3'd3; s_a0 = 7'h7F; s_b0 = 7'h0F;
    s_v1 = 1'b1; s_op1 = 3'd5; s_a1 = 7'h55; s_b1 = 7'h2A;
    run(16);
    s_keep = 1'b0; s_v0 = 1'b0; s_v1 = 1'b0;
    run(4);

    // Backpressure with the other port waiting, then release.
    s_v0 = 1'b1; s_op0 = 3'd4; s_a0 = 7'h12; s_b0 = 7'h41;
    run(1);
    s_rdy = 1'b0;
    s_v1 = 1'b1; s_op1 = 3'd1; s_a1 = 7'h20; s_b1 = 7'h22;
    run(6);
    s_v0 = 1'b1; s_op0 = 3'd2; s_a0 = 7'h01; s_b0 = 7'h02;
    s_rdy = 1'b1;
    run(10);

    // Illegal opcodes.
    s_v0 = 1'b1; s_op0 = 3'd7; s_a0 = 7'd9; s_b0 = 7'd9;
    run(4);
    s_v0 = 1'b1; s_op0 = 3'd0; s_a0 = 7'd9; s_b0 = 7'd9;
    run(4);
    s_v1 = 1'b1; s_op1 = 3'd6; s_a1 = 7'd33; s_b1 = 7'd44;
    run(4);

    // Reset during EXEC, then during a back-pressured RESP.
    s_v0 = 1'b1; s_op0 = 3'd1; s_a0 = 7'd1; s_b0 = 7'd2;
    run(1);
    s_rst = 1'b1; run(1); s_rst = 1'b0;
    s_v0 = 1'b1; s_v1 = 1'b1;
    s_rdy = 1'b0;
    run(3);
    s_rst = 1'b1; run(1); s_rst = 1'b0;
    s_rdy = 1'b1; s_v0 = 1'b1;
    run(10);

    // Random traffic with occasional reset.
    for (int i = 0; i < 800; i++) begin
      s_v0  = ($urandom % 3) != 0;
      s_op0 = OP_WIDTH'($urandom);
      s_a0  = WIDTH'($urandom);
      s_b0  = WIDTH'($urandom);
      s_v1  = ($urandom % 3) != 0;
      s_op1 = OP_WIDTH'($urandom);
      s_a1  = WIDTH'($urandom);
      s_b1  = WIDTH'($urandom);
      s_rdy = ($urandom % 4) != 0;
      s_rst = ($urandom % 64) == 0;
      cycle();
    end
    s_rst = 1'b0; s_v0 = 1'b0; s_v1 = 1'b0; s_rdy = 1'b1;
    run(6);
    check("queue_drained", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
